// File: rtl/multicycle_control.sv
// Control unit for a multicycle MIPS-subset datapath: owns the instruction
// register, sequences lw/sw/R-type/beq/j/addi and decodes the IR fields.
module multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [4:0]  rr1,
  output logic [4:0]  rr2,
  output logic [4:0]  wr,
  output logic [31:0] imm_ext,
  output logic [3:0]  state,
  output logic        illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t      cur;
  logic [31:0] ir;
  logic [5:0]  opcode;

  assign opcode  = ir[31:26];
  assign state   = cur;
  assign rr1     = ir[25:21];
  assign rr2     = ir[20:16];
  assign wr      = (opcode == OP_RTYPE) ? ir[15:11] : ir[20:16];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  // State sequencing and IR capture; reset overrides any pending transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur <= FETCH;
      ir  <= 32'd0;
    end else begin
      if (ir_write)
        ir <= mem_rdata;
      case (cur)
        FETCH:     cur <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur <= MEM_ADDR;
            OP_RTYPE:     cur <= EXEC_R;
            OP_BEQ:       cur <= BRANCH;
            OP_J:         cur <= JUMP;
            OP_ADDI:      cur <= EXEC_I;
            default:      cur <= FETCH;
          endcase
        end
        MEM_ADDR:  cur <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ:  cur <= mem_ready ? MEM_WB : MEM_READ;
        MEM_WRITE: cur <= mem_ready ? FETCH : MEM_WRITE;
        EXEC_R:    cur <= R_WB;
        EXEC_I:    cur <= I_WB;
        default:   cur <= FETCH;
      endcase
    end
  end

  // Control decode; everything not named for a state stays 0, and reset
  // silences all strobes so an aborted access cannot leak a write.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (!reset) begin
      case (cur)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
            default:                                       illegal = 1'b1;
          endcase
        end
        MEM_ADDR, EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_READ:  mem_req = 1'b1;
        MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        MEM_WB: begin
          reg_write  = (wr != 5'd0);
          mem_to_reg = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        R_WB, I_WB: reg_write = (wr != 5'd0);
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          pc_write  = alu_zero;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
